// File: rtl/seg_monitor.sv
// Receiver-side checker for the rotating 8-digit seven-segment bus.
// Debounces raw patterns, decodes glyphs and scores each rotation step.
module seg_monitor #(
    parameter int unsigned STABLE_CYC = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       i_seg0,
    input  logic [7:0]       i_seg1,
    input  logic [7:0]       i_seg2,
    input  logic [7:0]       i_seg3,
    input  logic [7:0]       i_seg4,
    input  logic [7:0]       i_seg5,
    input  logic [7:0]       i_seg6,
    input  logic [7:0]       i_seg7,
    output logic [31:0]      digit_o,
    output logic [7:0]       valid_o,
    output logic [7:0]       dp_o,
    output logic             sync_o,
    output logic             step_pulse,
    output logic             err_pulse,
    output logic [CNT_W-1:0] step_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [31:0]      last_interval
);

    typedef enum logic {
        UNSYNC = 1'b0,
        SYNCED = 1'b1
    } state_t;

    localparam logic [15:0]      STAB_MAX = 16'(STABLE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [31:0]      IVL_MAX  = '1;

    // Returns {valid, digit}; dp is masked before lookup.
    function automatic logic [4:0] decode(input logic [7:0] raw);
        logic [7:0] g;
        g = ~raw & 8'hFE;
        case (g)
            8'hFC:   decode = 5'h10;
            8'h60:   decode = 5'h11;
            8'hDA:   decode = 5'h12;
            8'hF2:   decode = 5'h13;
            8'h66:   decode = 5'h14;
            8'hB6:   decode = 5'h15;
            8'hBE:   decode = 5'h16;
            8'hE0:   decode = 5'h17;
            8'hFE:   decode = 5'h18;
            8'hF6:   decode = 5'h19;
            8'hEE:   decode = 5'h1A;
            8'h3E:   decode = 5'h1B;
            8'h9C:   decode = 5'h1C;
            8'h7A:   decode = 5'h1D;
            8'h9E:   decode = 5'h1E;
            8'h8E:   decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    logic [63:0]      s1_q, s1_d;
    logic [63:0]      cand_q, cand_d;
    logic [63:0]      acc_q, acc_d;
    logic [15:0]      stab_q, stab_d;
    logic [31:0]      ivl_q, ivl_d;
    logic             prior_q, prior_d;
    logic [31:0]      digit_q, digit_d;
    logic [7:0]       valid_q, valid_d;
    logic [7:0]       dp_q, dp_d;
    state_t           state_q, state_d;
    logic             step_q, step_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;
    logic [31:0]      last_q, last_d;

    logic             reach;
    logic             accept;
    logic [7:0][3:0]  nd;
    logic [7:0]       nv;
    logic [7:0]       ndp;
    logic             cons;
    logic             correct;

    assign s1_d = {i_seg7, i_seg6, i_seg5, i_seg4,
                   i_seg3, i_seg2, i_seg1, i_seg0};

    always_comb begin
        cand_d = cand_q;
        stab_d = stab_q;
        if (s1_q != cand_q) begin
            cand_d = s1_q;
            stab_d = 16'd1;
        end else if (stab_q != STAB_MAX) begin
            stab_d = stab_q + 16'd1;
        end
        reach  = (stab_d == STAB_MAX) &&
                 ((s1_q != cand_q) || (stab_q != STAB_MAX));
        accept = reach && (cand_d != acc_q);
    end

    always_comb begin
        nd   = '0;
        nv   = '0;
        ndp  = '0;
        for (int i = 0; i < 8; i++) begin
            {nv[i], nd[i]} = decode(cand_d[8*i +: 8]);
            ndp[i]         = ~cand_d[8*i];
        end
        cons = &nv;
        for (int i = 1; i < 8; i++) begin
            if (nd[i] != {1'b0, nd[0][2:0] + 3'(i)})
                cons = 1'b0;
        end
        // Reference is the previously accepted digit 0.
        correct = cons &&
                  (nd[0] == {1'b0, digit_q[2:0] + 3'd1});
    end

    always_comb begin
        acc_d   = acc_q;
        digit_d = digit_q;
        valid_d = valid_q;
        dp_d    = dp_q;
        state_d = state_q;
        step_d  = 1'b0;
        err_d   = 1'b0;
        scnt_d  = scnt_q;
        ecnt_d  = ecnt_q;
        if (accept) begin
            acc_d   = cand_d;
            digit_d = nd;
            valid_d = nv;
            dp_d    = ndp;
            unique case (state_q)
                UNSYNC: begin
                    if (cons)
                        state_d = SYNCED;
                end
                SYNCED: begin
                    if (correct) begin
                        step_d = 1'b1;
                        if (scnt_q != CNT_MAX)
                            scnt_d = scnt_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                        if (ecnt_q != CNT_MAX)
                            ecnt_d = ecnt_q + 1'b1;
                        if (!cons)
                            state_d = UNSYNC;
                    end
                end
            endcase
        end
    end

    always_comb begin
        ivl_d   = (ivl_q == IVL_MAX) ? ivl_q : ivl_q + 32'd1;
        last_d  = last_q;
        prior_d = prior_q | accept;
        if (accept) begin
            ivl_d = '0;
            if (prior_q)
                last_d = (ivl_q == IVL_MAX) ? IVL_MAX : ivl_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            cand_q  <= '0;
            acc_q   <= '0;
            stab_q  <= '0;
            ivl_q   <= '0;
            prior_q <= 1'b0;
            digit_q <= '0;
            valid_q <= '0;
            dp_q    <= '0;
            state_q <= UNSYNC;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
            scnt_q  <= '0;
            ecnt_q  <= '0;
            last_q  <= '0;
        end else begin
            s1_q    <= s1_d;
            cand_q  <= cand_d;
            acc_q   <= acc_d;
            stab_q  <= stab_d;
            ivl_q   <= ivl_d;
            prior_q <= prior_d;
            digit_q <= digit_d;
            valid_q <= valid_d;
            dp_q    <= dp_d;
            state_q <= state_d;
            step_q  <= step_d;
            err_q   <= err_d;
            scnt_q  <= scnt_d;
            ecnt_q  <= ecnt_d;
            last_q  <= last_d;
        end
    end

    assign digit_o       = digit_q;
    assign valid_o       = valid_q;
    assign dp_o          = dp_q;
    assign sync_o        = (state_q == SYNCED);
    assign step_pulse    = step_q;
    assign err_pulse     = err_q;
    assign step_cnt      = scnt_q;
    assign err_cnt       = ecnt_q;
    assign last_interval = last_q;

endmodule
